tanh1_stage: RTL and testbench

TANH1_STAGE -- requirements
Module: tanh1_stage

---
 rtl/tanh1_pkg.sv | 50 +++++
 rtl/tanh1_stage_if.sv | 38 +++
 rtl/tanh4_quant.sv | 28 ++
 rtl/tanh1_stage.sv | 110 +++++++++++
 tb/tb_tanh1_stage.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/tanh1_pkg.sv
// Shared widths, sample count and tanh threshold table for the layer-1 tanh stage.
package tanh1_pkg;

  localparam int unsigned InWidth    = 16;
  localparam int unsigned CodeWidth  = 4;
  localparam int unsigned NumSamples = 128;
  localparam int unsigned AddrWidth  = $clog2(NumSamples);
  // One extra bit so the counter can reach NumSamples and stop accepting.
  localparam int unsigned CntWidth   = AddrWidth + 1;
  localparam int unsigned NumLevels  = 7;
  // |x| needs one more bit than x so that -32768 has a representable magnitude.
  localparam int unsigned MagWidth   = InWidth + 1;

  // Q8.8 magnitude thresholds; entry k is the lower bound for level k+1.
  localparam logic [NumLevels-1:0][MagWidth-1:0] Thresh = {
    17'd290, 17'd216, 17'd163, 17'd120, 17'd83, 17'd49, 17'd16
  };

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Stage-1 pipeline register contents.
  typedef struct packed {
    logic                 valid;
    logic [AddrWidth-1:0] idx;
    logic [InWidth-1:0]   data;
  } s1_t;

  // Stage-2 pipeline register contents; these drive the tmem write port directly.
  typedef struct packed {
    logic                 wr;
    logic [AddrWidth-1:0] addr;
    logic [CodeWidth-1:0] code;
  } s2_t;

  // Absolute value of a signed InWidth value, widened so the most negative input is exact.
  function automatic logic [MagWidth-1:0] abs_mag(input logic [InWidth-1:0] x);
    logic [MagWidth-1:0] ext;
    ext = {x[InWidth-1], x};
    if (x[InWidth-1]) begin
      abs_mag = ~ext + MagWidth'(1);
    end else begin
      abs_mag = ext;
    end
  endfunction

endpackage

// File: rtl/tanh1_stage_if.sv
// Sample input / tmem write-port bundle between the affine1 datapath and the tanh stage.
interface tanh1_stage_if;
  import tanh1_pkg::*;

  logic                 start;
  logic [InWidth-1:0]   in_data;
  logic                 in_valid;
  logic [CodeWidth-1:0] data_out;
  logic [AddrWidth-1:0] wr_addr;
  logic                 wr;
  logic                 busy;
  logic                 done;

  // Controller / sample source side.
  modport master (
    output start,
    output in_data,
    output in_valid,
    input  data_out,
    input  wr_addr,
    input  wr,
    input  busy,
    input  done
  );

  // Tanh stage side.
  modport slave (
    input  start,
    input  in_data,
    input  in_valid,
    output data_out,
    output wr_addr,
    output wr,
    output busy,
    output done
  );

endinterface

// File: rtl/tanh4_quant.sv
// Combinational piecewise tanh: signed Q8.8 in, signed 4-bit code (value/8) out.
module tanh4_quant
  import tanh1_pkg::*;
(
  input  logic [InWidth-1:0]   x,
  output logic [CodeWidth-1:0] code
);

  logic [MagWidth-1:0]  mag;
  logic [CodeWidth-1:0] level;

  // Highest threshold met sets the level; the sign of x is reapplied afterwards.
  always_comb begin
    mag   = abs_mag(x);
    level = '0;
    for (int k = 0; k < NumLevels; k++) begin
      if (mag >= Thresh[k]) begin
        level = CodeWidth'(k + 1);
      end
    end
    if (x[InWidth-1]) begin
      code = ~level + CodeWidth'(1);
    end else begin
      code = level;
    end
  end

endmodule

// File: rtl/tanh1_stage.sv
// Layer-1 tanh stage: counts 128 samples per pass, quantizes them through a
// 2-stage pipeline and writes the codes to tmem at contiguous addresses.
module tanh1_stage
  import tanh1_pkg::*;
(
  input logic         clock,
  input logic         reset_n,
  tanh1_stage_if.slave bus
);

  localparam logic [CntWidth-1:0]  CntLimit = CntWidth'(NumSamples);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumSamples - 1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  s1_t                 s1_q, s1_d;
  s2_t                 s2_q, s2_d;

  logic                 start_ok;
  logic                 accept;
  logic                 last_wr;
  logic [CodeWidth-1:0] quant_code;

  // Start is only honoured from idle, so a start during the done cycle is dropped.
  assign start_ok = bus.start && (state_q == StIdle);
  // Samples are taken only while running and until the pass quota is reached.
  assign accept   = bus.in_valid && (state_q == StRun) && (cnt_q < CntLimit);
  // The write of the final address is what ends the pass, not its acceptance.
  assign last_wr  = s2_q.wr && (s2_q.addr == LastAddr);

  tanh4_quant u_quant (
    .x    (s1_q.data),
    .code (quant_code)
  );

  // Pass control FSM: idle -> run until the last write issues -> one done cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (last_wr) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Acceptance counter doubles as the write address of the next sample.
  always_comb begin
    cnt_d = cnt_q;
    if (start_ok) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  // Stage 1 captures the raw sample and its index; data holds when idle to avoid toggling.
  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = accept;
    if (accept) begin
      s1_d.idx  = cnt_q[AddrWidth-1:0];
      s1_d.data = bus.in_data;
    end
  end

  // Stage 2 captures the quantized code; address/code hold their last values between writes.
  always_comb begin
    s2_d    = s2_q;
    s2_d.wr = s1_q.valid;
    if (s1_q.valid) begin
      s2_d.addr = s1_q.idx;
      s2_d.code = quant_code;
    end
  end

  // All state, with synchronous reset abandoning any pass and in-flight samples.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  assign bus.data_out = s2_q.code;
  assign bus.wr_addr  = s2_q.addr;
  assign bus.wr       = s2_q.wr;
  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);

endmodule

// File: tb/tb_tanh1_stage.sv
// Scoreboard bench for tanh1_stage: expected writes are queued when samples are
// driven and compared when the write port produces them.
module tb_tanh1_stage;
  import tanh1_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  tanh1_stage_if bus ();

  tanh1_stage dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int         addr;
    logic [3:0] code;
    int         due;
  } exp_t;

  exp_t sb[$];

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  bit         m_busy   = 1'b0;
  bit         m_done   = 1'b0;
  bit         m_pend   = 1'b0;
  int         m_cnt    = 0;
  logic [3:0] m_code   = 4'd0;
  int         m_addr   = 0;
  int         thr[7]   = '{16, 49, 83, 120, 163, 216, 290};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference tanh code computed with plain integer arithmetic.
  function automatic logic [3:0] ref_code(input logic [15:0] d);
    int x;
    int a;
    int lvl;
    x   = $signed(d);
    a   = (x < 0) ? -x : x;
    lvl = 0;
    for (int k = 0; k < 7; k++) begin
      if (a >= thr[k]) lvl = k + 1;
    end
    if (x < 0) lvl = -lvl;
    return lvl[3:0];
  endfunction

  // One clock: drive inputs, update the model at the edge, compare outputs at the falling edge.
  task automatic tick(input bit v, input logic [15:0] d, input bit s, input bit r);
    exp_t e;
    bit   start_ok;
    bit   exp_wr;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.start    = s;
    reset_n      = r;
    @(posedge clock);
    if (!r) begin
      sb.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_pend = 1'b0;
      m_cnt  = 0;
      m_code = 4'd0;
      m_addr = 0;
    end else begin
      if (m_busy && v && m_cnt < 128) begin
        e.addr = m_cnt;
        e.code = ref_code(d);
        e.due  = cyc + 2;
        sb.push_back(e);
        m_cnt++;
      end
      start_ok = s && !m_busy && !m_done;
      m_done   = m_pend;
      if (m_pend) m_busy = 1'b0;
      m_pend = 1'b0;
      if (start_ok) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    cyc++;
    @(negedge clock);
    exp_wr = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e      = sb.pop_front();
      exp_wr = 1'b1;
      m_code = e.code;
      m_addr = e.addr;
      if (e.addr == 127) m_pend = 1'b1;
    end
    check("wr", 32'(bus.wr), 32'(exp_wr));
    check("data_out", 32'(bus.data_out), 32'(m_code));
    check("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("done", 32'(bus.done), 32'(m_done));
  endtask

  task automatic start_pass();
    tick(1'b0, 16'h0000, 1'b1, 1'b1);
  endtask

  // Idle until every queued write and the done pulse have been observed.
  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() > 0 || m_pend || m_done) && n < 40) begin
      tick(1'b0, 16'h0000, 1'b0, 1'b1);
      n++;
    end
    check("drain_bound", 32'(n < 40), 32'd1);
    tick(1'b0, 16'h0000, 1'b0, 1'b1);
  endtask

  logic [15:0] edge_vals[8];
  logic [15:0] v16;

  initial begin
    edge_vals = '{16'd15, 16'd16, 16'd289, 16'd290, 16'hfff0, 16'hfff1, 16'h7fff, 16'h8000};
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    @(negedge clock);

    // Reset, then samples offered before any start must be ignored.
    tick(1'b0, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 16'($urandom()), 1'b0, 1'b1);

    // Full back-to-back pass of k*4, a repeated start mid-pass, extra samples past the quota.
    start_pass();
    for (int k = 0; k < 131; k++) tick(1'b1, 16'(k * 4), (k == 20), 1'b1);
    drain();

    // Threshold edges first, random fill for the rest of the pass.
    start_pass();
    for (int i = 0; i < 128; i++) begin
      v16 = (i < 8) ? edge_vals[i] : 16'($urandom());
      tick(1'b1, v16, 1'b0, 1'b1);
    end
    drain();

    // Alternate-cycle valid for a whole pass: addresses must stay contiguous.
    start_pass();
    for (int i = 0; i < 256; i++) tick((i % 2 == 0), 16'($urandom_range(0, 700) - 350), 1'b0, 1'b1);
    drain();

    // Reset after 50 samples, then a fresh pass.
    start_pass();
    for (int i = 0; i < 50; i++) tick(1'b1, 16'($urandom()), 1'b0, 1'b1);
    tick(1'b1, 16'h1234, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 16'($urandom()), 1'b0, 1'b1);
    start_pass();
    for (int i = 0; i < 128; i++) tick(1'b1, 16'($urandom()), 1'b0, 1'b1);
    drain();

    // Start coincident with done is dropped; start one cycle later begins at address 0.
    start_pass();
    for (int i = 0; i < 128; i++) tick(1'b1, 16'($urandom_range(0, 600) - 300), 1'b0, 1'b1);
    begin
      int n;
      n = 0;
      while (!m_done && n < 20) begin
        tick(1'b0, 16'h0000, 1'b0, 1'b1);
        n++;
      end
      check("done_bound", 32'(n < 20), 32'd1);
    end
    tick(1'b0, 16'h0000, 1'b1, 1'b1);
    tick(1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 128; i++) tick(1'b1, 16'($urandom()), 1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
